// File: rtl/spi_resp_tx.sv
// spi_resp_tx: buffers one response frame and shifts it MSB-first on miso, clocked by sck.
module spi_resp_tx #(
  parameter int ID_W    = 8,
  parameter int FRAME_W = 40
) (
  input  logic            sck,
  input  logic            rst_n,
  input  logic            CS_n,
  input  logic            resp_valid,
  output logic            resp_ready,
  input  logic [3:0]      resp_opcode,
  input  logic [3:0]      status,
  input  logic [ID_W-1:0] vert_id_in,
  input  logic [ID_W-1:0] tri_id_in,
  input  logic [ID_W-1:0] inst_id_in,
  output logic            miso,
  output logic            tx_busy,
  output logic            tx_done,
  output logic            tx_abort,
  output logic [7:0]      frames_sent
);
  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;
  localparam int CW = $clog2(FRAME_W + 1);
  state_t state, state_nx;
  logic hold_full, accept, last;
  logic [FRAME_W-1:0] hold, shreg;
  logic [CW-1:0] bit_ctr;
  logic [7:0] chk;
  always_comb begin
    accept = resp_valid && !hold_full;
    last   = state == SHIFT && !CS_n && bit_ctr == CW'(FRAME_W - 1);
    chk    = {resp_opcode, status} ^ 8'(vert_id_in) ^ 8'(tri_id_in) ^ 8'(inst_id_in);
  end
  always_ff @(posedge sck or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (hold_full ? ARMED : IDLE) :
               state == ARMED ? (CS_n ? ARMED : SHIFT) :
               (CS_n || last) ? IDLE : SHIFT;
  end
  always_comb begin
    resp_ready = !hold_full;
    tx_busy    = state != IDLE;
  end
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      hold        <= '0;
      hold_full   <= 1'b0;
      shreg       <= '0;
      bit_ctr     <= '0;
      miso        <= 1'b0;
      tx_done     <= 1'b0;
      tx_abort    <= 1'b0;
      frames_sent <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      if (accept) begin
        hold      <= {resp_opcode, status, vert_id_in, tri_id_in, inst_id_in, chk};
        hold_full <= 1'b1;
      end else if (state == IDLE && hold_full) begin
        hold_full <= 1'b0;
      end
      if (state == IDLE) begin
        miso <= 1'b0;
        if (hold_full) shreg <= hold;
      end else if (CS_n) begin
        miso     <= 1'b0;
        bit_ctr  <= '0;
        tx_abort <= state == SHIFT;
      end else begin
        miso    <= shreg[FRAME_W-1];
        shreg   <= {shreg[FRAME_W-2:0], 1'b0};
        bit_ctr <= state == ARMED ? CW'(1) : bit_ctr + CW'(1);
        if (last) begin
          tx_done     <= 1'b1;
          frames_sent <= frames_sent + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_resp_tx.sv
// tb_spi_resp_tx: randomized frame-level checks of spi_resp_tx against a field-based reference model.
module tb_spi_resp_tx;
  logic sck = 0, rst_n = 0, CS_n = 1, resp_valid = 0;
  logic resp_ready, miso, tx_busy, tx_done, tx_abort;
  logic [3:0] resp_opcode = 0, status = 0;
  logic [7:0] vert_id_in = 0, tri_id_in = 0, inst_id_in = 0, frames_sent;
  int checks = 0, errors = 0, done_cnt = 0, abort_cnt = 0, sent = 0;
  always #5 sck = ~sck;
  spi_resp_tx dut (
    .sck(sck), .rst_n(rst_n), .CS_n(CS_n), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_opcode(resp_opcode), .status(status), .vert_id_in(vert_id_in), .tri_id_in(tri_id_in),
    .inst_id_in(inst_id_in), .miso(miso), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_abort(tx_abort), .frames_sent(frames_sent)
  );
  always @(posedge sck) begin
    #1;
    if (tx_done) done_cnt++;
    if (tx_abort) abort_cnt++;
  end
  function automatic logic [39:0] mk(logic [31:0] f);
    return {f, f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0]};
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge sck);
  endtask
  task automatic drive(logic [31:0] f);
    {resp_opcode, status, vert_id_in, tri_id_in, inst_id_in} = f;
  endtask
  task automatic accept(logic [31:0] f);
    int w = 0;
    while (!resp_ready && w < 200) begin
      tick(1);
      w++;
    end
    check("accept_wait", w < 200, 1);
    drive(f);
    resp_valid = 1;
    tick(1);
    resp_valid = 0;
  endtask
  task automatic recv(string tag, logic [39:0] exp, int acc_at, logic [31:0] nf);
    logic [39:0] got;
    int dn = 0, da = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      got[39-i] = miso;
      if (tx_done) begin
        dn++;
        da = i;
      end
      resp_valid = 0;
      if (i == acc_at) begin
        drive(nf);
        resp_valid = 1;
      end
    end
    check({tag, "_data"}, got, exp);
    check({tag, "_done"}, dn, 1);
    check({tag, "_done_at"}, da, 39);
    sent++;
    check({tag, "_frames"}, frames_sent, sent % 256);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end
  initial begin
    logic [31:0] fa, fb;
    logic [39:0] e;
    logic [16:0] g17;
    int a0, d0;
    tick(2);
    check("rst_ready", resp_ready, 1);
    check("rst_miso", miso, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_abort", tx_abort, 0);
    check("rst_frames", frames_sent, 0);
    rst_n = 1;
    tick(1);
    accept(32'h3A123456);
    check("basic_ready", resp_ready, 0);
    CS_n = 0;
    tick(1);
    check("basic_armed_busy", tx_busy, 1);
    check("basic_armed_miso", miso, 0);
    recv("basic", 40'h3A1234564A, -1, 0);
    check("basic_idle_busy", tx_busy, 0);
    CS_n = 1;
    tick(1);
    check("basic_idle_miso", miso, 0);
    for (int k = 0; k < 12; k++) begin
      fa = $urandom;
      accept(fa);
      for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
        tick(1);
        check("rand_armed_miso", miso, 0);
        check("rand_armed_busy", tx_busy, 1);
      end
      CS_n = 0;
      recv("rand", mk(fa), -1, 0);
      CS_n = 1;
      tick(1);
    end
    for (int k = 0; k < 6; k++) begin
      fa = $urandom;
      fb = $urandom;
      accept(fa);
      CS_n = 0;
      tick(1);
      recv("b2b_a", mk(fa), k == 0 ? 38 : int'($urandom_range(0, 37)), fb);
      resp_valid = 0;
      check("b2b_ready", resp_ready, 0);
      tick(1);
      check("b2b_gap_miso", miso, 0);
      check("b2b_gap_busy", tx_busy, 1);
      recv("b2b_b", mk(fb), -1, 0);
      CS_n = 1;
      tick(1);
    end
    fa = $urandom;
    fb = $urandom;
    accept(fa);
    tick(1);
    accept(fb);
    for (int j = 0; j < 10; j++) begin
      drive($urandom);
      resp_valid = 1;
      tick(1);
      check("bp_ready", resp_ready, 0);
      check("bp_miso", miso, 0);
    end
    resp_valid = 0;
    CS_n = 0;
    recv("bp_a", mk(fa), -1, 0);
    tick(1);
    recv("bp_b", mk(fb), -1, 0);
    CS_n = 1;
    tick(1);
    fa = $urandom;
    fb = $urandom;
    a0 = abort_cnt;
    accept(fa);
    CS_n = 0;
    tick(1);
    for (int i = 0; i < 17; i++) begin
      tick(1);
      g17[16-i] = miso;
      resp_valid = (i == 3);
      if (i == 3) drive(fb);
    end
    resp_valid = 0;
    e = mk(fa) >> 23;
    check("abort_bits", g17, e[16:0]);
    CS_n = 1;
    tick(1);
    check("abort_pulse", tx_abort, 1);
    check("abort_miso", miso, 0);
    check("abort_busy", tx_busy, 0);
    check("abort_frames", frames_sent, sent % 256);
    check("abort_hold_ready", resp_ready, 0);
    tick(1);
    check("abort_pulse_end", tx_abort, 0);
    check("abort_rearm_busy", tx_busy, 1);
    check("abort_rearm_ready", resp_ready, 1);
    CS_n = 0;
    recv("abort_b", mk(fb), -1, 0);
    CS_n = 1;
    tick(1);
    check("abort_count", abort_cnt - a0, 1);
    fa = $urandom;
    fb = $urandom;
    accept(fa);
    CS_n = 0;
    tick(1);
    accept(fb);
    tick($urandom_range(3, 30));
    a0 = abort_cnt;
    #1 rst_n = 0;
    #1;
    check("arst_miso", miso, 0);
    check("arst_busy", tx_busy, 0);
    check("arst_done", tx_done, 0);
    check("arst_abort", tx_abort, 0);
    check("arst_frames", frames_sent, 0);
    check("arst_ready", resp_ready, 1);
    #1 rst_n = 1;
    sent = 0;
    CS_n = 1;
    tick(3);
    check("arst_no_abort", abort_cnt - a0, 0);
    check("arst_idle_busy", tx_busy, 0);
    check("arst_idle_frames", frames_sent, 0);
    d0 = done_cnt;
    for (int k = 0; k < 256; k++) begin
      fa = $urandom;
      accept(fa);
      CS_n = 0;
      tick(1);
      recv("wrap", mk(fa), -1, 0);
      CS_n = 1;
      tick(1);
    end
    check("wrap_frames", frames_sent, 0);
    check("wrap_dones", done_cnt - d0, 256);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
